// File: rtl/matmul_seq_if.sv
// Control/address bundle between the matrix-multiply loop sequencer and its core.
// Master drives run parameters and stall; slave (the sequencer) drives addresses and strobes.
interface matmul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dim_m;
  logic [WIDTH-1:0] dim_k;
  logic [WIDTH-1:0] dim_n;
  logic [WIDTH-1:0] base_a;
  logic [WIDTH-1:0] base_b;
  logic [WIDTH-1:0] base_c;
  logic             stall;
  logic [WIDTH-1:0] addr_a;
  logic [WIDTH-1:0] addr_b;
  logic             rd_valid;
  logic             acc_clr;
  logic [WIDTH-1:0] addr_c;
  logic             wr_en;
  logic             busy;
  logic             done;

  modport master (
    output start, dim_m, dim_k, dim_n, base_a, base_b, base_c, stall,
    input  addr_a, addr_b, rd_valid, acc_clr, addr_c, wr_en, busy, done
  );

  modport slave (
    input  start, dim_m, dim_k, dim_n, base_a, base_b, base_c, stall,
    output addr_a, addr_b, rd_valid, acc_clr, addr_c, wr_en, busy, done
  );
endinterface

// File: rtl/matmul_seq.sv
// i/j/k loop sequencer for C = A x B: one MAC read per FETCH cycle, one write-back per WRITE cycle.
// Latency: first read the cycle after start; stall freezes everything. MATSEQ_TRANSPOSE_B_EN selects N x K storage of B.
module matmul_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  matmul_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] dim_m_q, dim_m_d;
  logic [WIDTH-1:0] dim_k_q, dim_k_d;
  logic [WIDTH-1:0] dim_n_q, dim_n_d;
  logic [WIDTH-1:0] base_b_q, base_b_d;
  logic [WIDTH-1:0] row_a_q, row_a_d;
  logic [WIDTH-1:0] col_b_q, col_b_d;
  logic [WIDTH-1:0] addr_a_q, addr_a_d;
  logic [WIDTH-1:0] addr_b_q, addr_b_d;
  logic [WIDTH-1:0] addr_c_q, addr_c_d;

  // B stride per k step and per column step, depending on storage order of B.
  logic [WIDTH-1:0] step_k_b;
  logic [WIDTH-1:0] step_j_b;
`ifdef MATSEQ_TRANSPOSE_B_EN
  assign step_k_b = ONE;
  assign step_j_b = dim_k_q;
`else
  assign step_k_b = dim_n_q;
  assign step_j_b = ONE;
`endif

  logic last_k;
  logic last_j;
  logic last_i;
  assign last_k = (k_q == dim_k_q - ONE);
  assign last_j = (j_q == dim_n_q - ONE);
  assign last_i = (i_q == dim_m_q - ONE);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    dim_m_d  = dim_m_q;
    dim_k_d  = dim_k_q;
    dim_n_d  = dim_n_q;
    base_b_d = base_b_q;
    row_a_d  = row_a_q;
    col_b_d  = col_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dim_m_d  = bus.dim_m;
          dim_k_d  = bus.dim_k;
          dim_n_d  = bus.dim_n;
          base_b_d = bus.base_b;
          i_d      = ZERO;
          j_d      = ZERO;
          k_d      = ZERO;
          row_a_d  = bus.base_a;
          col_b_d  = bus.base_b;
          addr_a_d = bus.base_a;
          addr_b_d = bus.base_b;
          addr_c_d = bus.base_c;
          if ((bus.dim_m != ZERO) && (bus.dim_k != ZERO) && (bus.dim_n != ZERO)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        if (!bus.stall) begin
          if (last_k) begin
            state_d = S_WRITE;
          end else begin
            k_d      = k_q + ONE;
            addr_a_d = addr_a_q + ONE;
            addr_b_d = addr_b_q + step_k_b;
          end
        end
      end

      S_WRITE: begin
        if (!bus.stall) begin
          addr_c_d = addr_c_q + ONE;
          k_d      = ZERO;
          if (last_i && last_j) begin
            state_d = S_DONE;
          end else if (last_j) begin
            // Next row of C: A row base advances by K, B restarts at column 0.
            state_d  = S_FETCH;
            j_d      = ZERO;
            i_d      = i_q + ONE;
            row_a_d  = row_a_q + dim_k_q;
            addr_a_d = row_a_q + dim_k_q;
            col_b_d  = base_b_q;
            addr_b_d = base_b_q;
          end else begin
            state_d  = S_FETCH;
            j_d      = j_q + ONE;
            addr_a_d = row_a_q;
            col_b_d  = col_b_q + step_j_b;
            addr_b_d = col_b_q + step_j_b;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      base_b_q <= '0;
      row_a_q  <= '0;
      col_b_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      base_b_q <= base_b_d;
      row_a_q  <= row_a_d;
      col_b_q  <= col_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
    end
  end

  // Strobes are combinational so a stall suppresses them in the same cycle.
  assign bus.addr_a   = addr_a_q;
  assign bus.addr_b   = addr_b_q;
  assign bus.addr_c   = addr_c_q;
  assign bus.rd_valid = (state_q == S_FETCH) && !bus.stall;
  assign bus.acc_clr  = (state_q == S_FETCH) && !bus.stall && (k_q == ZERO);
  assign bus.wr_en    = (state_q == S_WRITE) && !bus.stall;
  assign bus.busy     = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: per-cycle vector table for the 2x2x2 run plus stall, zero-dim, reset and wrap sequences.
module tb_matmul_seq;

  logic clk;
  logic rst;

  matmul_seq_if #(.WIDTH(16)) bus ();

  matmul_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        ac;
    logic        wr;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] oa    [64];
  logic [15:0] ob    [64];
  logic [15:0] oc    [64];
  logic        orv   [64];
  logic        oac   [64];
  logic        owr   [64];
  logic        obusy [64];
  logic        odone [64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_run(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                         input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    bus.dim_m  = m;
    bus.dim_k  = k;
    bus.dim_n  = n;
    bus.base_a = ba;
    bus.base_b = bb;
    bus.base_c = bc;
  endtask

  // Start accepted at the edge ending cycle 0; cycle c is sampled at the negedge after edge c-1.
  task automatic run(input int ncyc, input logic [63:0] stall_map, input int start_again);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == start_again);
      bus.stall = stall_map[c];
      @(negedge clk);
      orv[c]   = bus.rd_valid;
      oac[c]   = bus.acc_clr;
      owr[c]   = bus.wr_en;
      obusy[c] = bus.busy;
      odone[c] = bus.done;
      oa[c]    = bus.addr_a;
      ob[c]    = bus.addr_b;
      oc[c]    = bus.addr_c;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  function automatic int first_done(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      if (odone[c]) return c;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic rv, input logic ac, input logic wr, input logic busy,
                              input logic done, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c);
    vec_t v;
    v.rv = rv; v.ac = ac; v.wr = wr; v.busy = busy; v.done = done;
    v.a = a; v.b = b; v.c = c;
    return v;
  endfunction

  vec_t tbl [1:14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    int nrv;
    int nwr;
    logic [15:0] b_k1;

`ifdef MATSEQ_TRANSPOSE_B_EN
    tbl[1]  = mk(1, 1, 0, 1, 0, 16'd0, 16'd16, 16'd32);
    tbl[2]  = mk(1, 0, 0, 1, 0, 16'd1, 16'd17, 16'd32);
    tbl[4]  = mk(1, 1, 0, 1, 0, 16'd0, 16'd18, 16'd33);
    tbl[5]  = mk(1, 0, 0, 1, 0, 16'd1, 16'd19, 16'd33);
    tbl[7]  = mk(1, 1, 0, 1, 0, 16'd2, 16'd16, 16'd34);
    tbl[8]  = mk(1, 0, 0, 1, 0, 16'd3, 16'd17, 16'd34);
    tbl[10] = mk(1, 1, 0, 1, 0, 16'd2, 16'd18, 16'd35);
    tbl[11] = mk(1, 0, 0, 1, 0, 16'd3, 16'd19, 16'd35);
    b_k1 = 16'd17;
`else
    tbl[1]  = mk(1, 1, 0, 1, 0, 16'd0, 16'd16, 16'd32);
    tbl[2]  = mk(1, 0, 0, 1, 0, 16'd1, 16'd18, 16'd32);
    tbl[4]  = mk(1, 1, 0, 1, 0, 16'd0, 16'd17, 16'd33);
    tbl[5]  = mk(1, 0, 0, 1, 0, 16'd1, 16'd19, 16'd33);
    tbl[7]  = mk(1, 1, 0, 1, 0, 16'd2, 16'd16, 16'd34);
    tbl[8]  = mk(1, 0, 0, 1, 0, 16'd3, 16'd18, 16'd34);
    tbl[10] = mk(1, 1, 0, 1, 0, 16'd2, 16'd17, 16'd35);
    tbl[11] = mk(1, 0, 0, 1, 0, 16'd3, 16'd19, 16'd35);
    b_k1 = 16'd18;
`endif
    tbl[3]  = mk(0, 0, 1, 1, 0, 16'd0, 16'd0, 16'd32);
    tbl[6]  = mk(0, 0, 1, 1, 0, 16'd0, 16'd0, 16'd33);
    tbl[9]  = mk(0, 0, 1, 1, 0, 16'd0, 16'd0, 16'd34);
    tbl[12] = mk(0, 0, 1, 1, 0, 16'd0, 16'd0, 16'd35);
    tbl[13] = mk(0, 0, 0, 0, 1, 16'd0, 16'd0, 16'd0);
    tbl[14] = mk(0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);

    rst = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    set_run(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("reset addr_a", {16'd0, bus.addr_a}, 32'd0);
    chk("reset addr_b", {16'd0, bus.addr_b}, 32'd0);
    chk("reset addr_c", {16'd0, bus.addr_c}, 32'd0);

    // Basic 2x2x2 run against the per-cycle table.
    set_run(16'd2, 16'd2, 16'd2, 16'd0, 16'd16, 16'd32);
    run(14, 64'd0, 0);
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("basic c%0d rd_valid", c), {31'd0, orv[c]}, {31'd0, tbl[c].rv});
      chk($sformatf("basic c%0d acc_clr", c), {31'd0, oac[c]}, {31'd0, tbl[c].ac});
      chk($sformatf("basic c%0d wr_en", c), {31'd0, owr[c]}, {31'd0, tbl[c].wr});
      chk($sformatf("basic c%0d busy", c), {31'd0, obusy[c]}, {31'd0, tbl[c].busy});
      chk($sformatf("basic c%0d done", c), {31'd0, odone[c]}, {31'd0, tbl[c].done});
      if (tbl[c].rv) begin
        chk($sformatf("basic c%0d addr_a", c), {16'd0, oa[c]}, {16'd0, tbl[c].a});
        chk($sformatf("basic c%0d addr_b", c), {16'd0, ob[c]}, {16'd0, tbl[c].b});
      end
      if (tbl[c].wr) begin
        chk($sformatf("basic c%0d addr_c", c), {16'd0, oc[c]}, {16'd0, tbl[c].c});
      end
    end

    // Stall for cycles 2..4 at the second read of the first element.
    run(18, 64'h1C, 0);
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("stall c%0d rd_valid", c), {31'd0, orv[c]}, 32'd0);
      chk($sformatf("stall c%0d acc_clr", c), {31'd0, oac[c]}, 32'd0);
      chk($sformatf("stall c%0d busy", c), {31'd0, obusy[c]}, 32'd1);
      chk($sformatf("stall c%0d addr_a", c), {16'd0, oa[c]}, 32'd1);
      chk($sformatf("stall c%0d addr_b", c), {16'd0, ob[c]}, {16'd0, b_k1});
    end
    chk("stall c5 rd_valid", {31'd0, orv[5]}, 32'd1);
    chk("stall c5 addr_a", {16'd0, oa[5]}, 32'd1);
    chk("stall c5 addr_b", {16'd0, ob[5]}, {16'd0, b_k1});
    chk("stall c6 wr_en", {31'd0, owr[6]}, 32'd1);
    d = first_done(18);
    chk("stall done cycle", d, 32'd16);
    nrv = 0;
    nwr = 0;
    for (int c = 1; c <= 18; c++) begin
      nrv += int'(orv[c]);
      nwr += int'(owr[c]);
    end
    chk("stall read count", nrv, 32'd8);
    chk("stall write count", nwr, 32'd4);

    // Zero inner dimension: immediate done, no traffic.
    set_run(16'd2, 16'd0, 16'd2, 16'd0, 16'd16, 16'd32);
    run(4, 64'd0, 0);
    chk("zero-k done c1", {31'd0, odone[1]}, 32'd1);
    chk("zero-k busy c1", {31'd0, obusy[1]}, 32'd0);
    nrv = 0;
    nwr = 0;
    for (int c = 1; c <= 4; c++) begin
      nrv += int'(orv[c]);
      nwr += int'(owr[c]);
    end
    chk("zero-k read count", nrv, 32'd0);
    chk("zero-k write count", nwr, 32'd0);

    // Reset asserted during the WRITE of element 2 (cycle 6).
    set_run(16'd2, 16'd2, 16'd2, 16'd0, 16'd16, 16'd32);
    run(5, 64'd0, 0);
    @(posedge clk);
    #1;
    chk("pre-reset wr_en", {31'd0, bus.wr_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid-reset wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("mid-reset busy", {31'd0, bus.busy}, 32'd0);
    chk("mid-reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("mid-reset addr_c", {16'd0, bus.addr_c}, 32'd0);
    chk("mid-reset addr_a", {16'd0, bus.addr_a}, 32'd0);
    chk("mid-reset addr_b", {16'd0, bus.addr_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_run(16'd1, 16'd3, 16'd1, 16'd0, 16'd16, 16'd32);
    run(7, 64'd0, 0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("post-reset c%0d rd_valid", c), {31'd0, orv[c]}, 32'd1);
      chk($sformatf("post-reset c%0d addr_a", c), {16'd0, oa[c]}, c - 1);
      chk($sformatf("post-reset c%0d addr_b", c), {16'd0, ob[c]}, 16 + c - 1);
    end
    chk("post-reset acc_clr c1", {31'd0, oac[1]}, 32'd1);
    chk("post-reset wr_en c4", {31'd0, owr[4]}, 32'd1);
    chk("post-reset addr_c c4", {16'd0, oc[4]}, 32'd32);
    d = first_done(7);
    chk("post-reset done cycle", d, 32'd5);

    // Address wrap plus a start pulse while busy that must be ignored.
    set_run(16'd1, 16'd3, 16'd1, 16'hFFFE, 16'd16, 16'd32);
    run(8, 64'd0, 2);
    chk("wrap c1 addr_a", {16'd0, oa[1]}, 32'h0000FFFE);
    chk("wrap c2 addr_a", {16'd0, oa[2]}, 32'h0000FFFF);
    chk("wrap c3 addr_a", {16'd0, oa[3]}, 32'h00000000);
    chk("wrap c3 rd_valid", {31'd0, orv[3]}, 32'd1);
    d = first_done(8);
    chk("wrap done cycle", d, 32'd5);
    chk("wrap c6 busy", {31'd0, obusy[6]}, 32'd0);
    chk("wrap c7 busy", {31'd0, obusy[7]}, 32'd0);
    chk("wrap c8 done", {31'd0, odone[8]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
